// File: rtl/sdram_wb_arbiter.sv
// Three-master to one-slave Wishbone arbiter in front of the SDRAM controller port.
// Single-beat transfers, bounded CPU priority, DMA round-robin, and a slave-hang watchdog.
module sdram_wb_arbiter #(
  parameter int unsigned TIMEOUT       = 64,
  parameter int unsigned CPU_BURST_MAX = 4,
  parameter logic [31:0] ERR_DATA      = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic [2:0]  m_cyc,
  input  logic [2:0]  m_stb,
  input  logic [2:0]  m_we,
  input  logic [11:0] m_sel,
  input  logic [95:0] m_adr,
  input  logic [95:0] m_dat_w,
  output logic [2:0]  m_ack,
  output logic [31:0] m_dat_r,
  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  output logic [3:0]  s_sel,
  output logic [31:0] s_adr,
  output logic [31:0] s_dat_w,
  input  logic        s_ack,
  input  logic [31:0] s_dat_r,
  output logic [2:0]  grant,
  output logic        timeout_o
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam int unsigned SW = $clog2(CPU_BURST_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    grant_q, grant_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          last_dma_q, last_dma_d;  // 0: master 1 last, 1: master 2 last
  logic [TW-1:0] timer_q, timer_d;

  logic [2:0] req;
  logic       dma_pend;
  logic       cpu_wins;
  logic [2:0] winner;
  logic [1:0] own_idx;

  assign req      = m_cyc & m_stb;
  assign dma_pend = req[1] | req[2];
  assign cpu_wins = req[0] & (~dma_pend | (streak_q < SW'(CPU_BURST_MAX)));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    winner = 3'b000;
    if (cpu_wins)                winner = 3'b001;
    else if (req[1] && req[2])   winner = last_dma_q ? 3'b010 : 3'b100;
    else if (req[1])             winner = 3'b010;
    else if (req[2])             winner = 3'b100;
  end

  always_comb begin
    own_idx = 2'd0;
    if (grant_q[2])      own_idx = 2'd2;
    else if (grant_q[1]) own_idx = 2'd1;
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    streak_d   = streak_q;
    last_dma_d = last_dma_q;
    timer_d    = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_OWN;
          grant_d = winner;
          timer_d = '0;
          if (winner[0]) begin
            if (dma_pend && (streak_q < SW'(CPU_BURST_MAX)))
              streak_d = streak_q + SW'(1);
          end else begin
            streak_d   = '0;
            last_dma_d = winner[2];
          end
        end
      end
      ST_OWN: begin
        // Ack beats both an owner abandon and watchdog expiry in the same cycle.
        if (s_ack || !m_cyc[own_idx]) begin
          state_d = ST_IDLE;
          grant_d = 3'b000;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = ST_ABORT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_ABORT: begin
        state_d = ST_IDLE;
        grant_d = 3'b000;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 3'b000;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= 3'b000;
      streak_q   <= '0;
      last_dma_q <= 1'b1;
      timer_q    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update together.
      state_q    <= state_d;
      grant_q    <= grant_d;
      streak_q   <= streak_d;
      last_dma_q <= last_dma_d;
      timer_q    <= timer_d;
    end
  end

  // Slave side is a pure mux of the owner, so an async reset drops s_cyc immediately.
  always_comb begin
    s_cyc     = 1'b0;
    s_stb     = 1'b0;
    s_we      = 1'b0;
    s_sel     = 4'h0;
    s_adr     = 32'h0;
    s_dat_w   = 32'h0;
    m_ack     = 3'b000;
    m_dat_r   = 32'h0;
    timeout_o = 1'b0;
    case (state_q)
      ST_OWN: begin
        s_cyc   = m_cyc[own_idx];
        s_stb   = req[own_idx];
        s_we    = m_we[own_idx];
        case (own_idx)
          2'd1: begin
            s_sel   = m_sel[7:4];
            s_adr   = m_adr[63:32];
            s_dat_w = m_dat_w[63:32];
          end
          2'd2: begin
            s_sel   = m_sel[11:8];
            s_adr   = m_adr[95:64];
            s_dat_w = m_dat_w[95:64];
          end
          default: begin
            s_sel   = m_sel[3:0];
            s_adr   = m_adr[31:0];
            s_dat_w = m_dat_w[31:0];
          end
        endcase
        m_ack   = grant_q & {3{s_ack}};
        m_dat_r = s_dat_r;
      end
      ST_ABORT: begin
        m_ack     = grant_q;
        m_dat_r   = ERR_DATA;
        timeout_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign grant = grant_q;

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Directed bench for sdram_wb_arbiter: arbitration order, latency, watchdog abort,
// owner abandon and asynchronous reset, against hand-computed expectations.
module tb_sdram_wb_arbiter;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_n = 1'b0;
  logic [2:0]  m_cyc = '0, m_stb = '0, m_we = '0;
  logic [11:0] m_sel = '0;
  logic [95:0] m_adr = '0, m_dat_w = '0;
  logic [2:0]  m_ack;
  logic [31:0] m_dat_r;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_dat_w;
  logic        s_ack = 1'b0;
  logic [31:0] s_dat_r = 32'hCAFE_F00D;
  logic [2:0]  grant;
  logic        timeout_o;

  int         errors = 0;
  int         checks = 0;
  int         s_lat  = 0;    // wait cycles before slave ack; -1 never acks
  int         busy   = 0;
  logic [2:0] keep     = '0; // masters that re-request after each ack
  logic [2:0] prev_ack = '0;
  int         acks, touts;

  sdram_wb_arbiter dut (
    .wb_clk_i (wb_clk_i), .wb_rst_n (wb_rst_n),
    .m_cyc    (m_cyc),    .m_stb    (m_stb),    .m_we    (m_we),
    .m_sel    (m_sel),    .m_adr    (m_adr),    .m_dat_w (m_dat_w),
    .m_ack    (m_ack),    .m_dat_r  (m_dat_r),
    .s_cyc    (s_cyc),    .s_stb    (s_stb),    .s_we    (s_we),
    .s_sel    (s_sel),    .s_adr    (s_adr),    .s_dat_w (s_dat_w),
    .s_ack    (s_ack),    .s_dat_r  (s_dat_r),
    .grant    (grant),    .timeout_o(timeout_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic on, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat);
    m_cyc[i]           = on;
    m_stb[i]           = on;
    m_we[i]            = we;
    m_sel[4*i +: 4]    = 4'hF;
    m_adr[32*i +: 32]  = adr;
    m_dat_w[32*i +: 32] = dat;
  endtask

  // One clock: masters retire acked requests, slave answers, outputs settle.
  task automatic tick();
    @(posedge wb_clk_i);
    #1;
    for (int i = 0; i < 3; i++)
      if (prev_ack[i] && !keep[i]) begin
        m_cyc[i] = 1'b0;
        m_stb[i] = 1'b0;
      end
    #1;
    if (s_cyc && s_stb) begin
      s_ack = (s_lat >= 0) && (busy == s_lat);
      busy  = s_ack ? 0 : busy + 1;
    end else begin
      s_ack = 1'b0;
      busy  = 0;
    end
    #1;
    prev_ack = m_ack;
  endtask

  logic [2:0] exp2 [8]  = '{3'b010, 3'b000, 3'b100, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000};
  logic [2:0] exp3 [10] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010,
                            3'b001, 3'b001, 3'b001, 3'b001, 3'b100};

  initial begin
    // Reset state
    tick(); tick();
    check("rst_grant", grant, 3'b000);
    check("rst_scyc", s_cyc, 1'b0);
    check("rst_mack", m_ack, 3'b000);
    check("rst_mdatr", m_dat_r, 32'h0);
    check("rst_tout", timeout_o, 1'b0);
    wb_rst_n = 1'b1;
    tick();
    check("idle_grant", grant, 3'b000);

    // CPU single write, ack on third OWN cycle
    s_lat = 2;
    set_req(0, 1'b1, 1'b1, 32'h3800_0000, 32'h1234_5678);
    acks = 0;
    tick();
    check("t1_grant", grant, 3'b001);
    check("t1_scyc", s_cyc, 1'b1);
    check("t1_sstb", s_stb, 1'b1);
    check("t1_swe", s_we, 1'b1);
    check("t1_ssel", s_sel, 4'hF);
    check("t1_sadr", s_adr, 32'h3800_0000);
    check("t1_sdatw", s_dat_w, 32'h1234_5678);
    check("t1_noack", m_ack, 3'b000);
    tick();
    tick();
    check("t1_ack", m_ack, 3'b001);
    acks = 1;
    tick();
    check("t1_release", grant, 3'b000);
    acks += int'(m_ack[0]);
    tick();
    acks += int'(m_ack[0]);
    check("t1_ackcount", acks, 1);
    check("t1_idle", grant, 3'b000);

    // DMA round-robin, slave acks immediately
    s_lat = 0;
    keep  = 3'b110;
    set_req(1, 1'b1, 1'b0, 32'h1000_0000, 32'h0);
    set_req(2, 1'b1, 1'b0, 32'h2000_0000, 32'h0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("t2_grant%0d", k), grant, exp2[k]);
      check($sformatf("t2_ack%0d", k), m_ack, exp2[k]);
    end
    m_cyc = '0; m_stb = '0; keep = '0;
    tick();

    // All three: CPU streak bounded by CPU_BURST_MAX
    keep = 3'b111;
    set_req(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h1000_0000, 32'h0);
    set_req(2, 1'b1, 1'b0, 32'h2000_0000, 32'h0);
    for (int k = 0; k < 20; k++) begin
      tick();
      check($sformatf("t3_grant%0d", k), grant, (k % 2 == 0) ? exp3[k/2] : 3'b000);
    end
    m_cyc = '0; m_stb = '0; keep = '0;
    tick();

    // Ack in the very cycle the watchdog expires: ack wins
    s_lat = 63;
    set_req(0, 1'b1, 1'b0, 32'h0000_0200, 32'h0);
    acks = 0; touts = 0;
    for (int k = 0; k < 64; k++) begin
      tick();
      acks  += int'(m_ack[0]);
      touts += int'(timeout_o);
    end
    check("te_grant", grant, 3'b001);
    check("te_ack", m_ack, 3'b001);
    check("te_ackcount", acks, 1);
    tick();
    touts += int'(timeout_o);
    check("te_notout", touts, 0);
    check("te_release", grant, 3'b000);

    // Slave never acks: abort after 64 OWN cycles, then next master
    s_lat = -1;
    set_req(1, 1'b1, 1'b0, 32'h1000_0040, 32'h0);
    set_req(2, 1'b1, 1'b0, 32'h2000_0040, 32'h0);
    acks = 0; touts = 0;
    for (int k = 0; k < 64; k++) begin
      tick();
      acks  += int'(|m_ack);
      touts += int'(timeout_o);
    end
    check("t4_wait_grant", grant, 3'b010);
    check("t4_wait_stb", s_stb, 1'b1);
    check("t4_wait_acks", acks, 0);
    check("t4_wait_touts", touts, 0);
    tick();
    check("t4_tout", timeout_o, 1'b1);
    check("t4_abort_ack", m_ack, 3'b010);
    check("t4_abort_data", m_dat_r, 32'hDEAD_BEEF);
    check("t4_abort_scyc", s_cyc, 1'b0);
    tick();
    check("t4_tout_pulse", timeout_o, 1'b0);
    check("t4_idle", grant, 3'b000);
    s_lat = 0;
    tick();
    check("t4_next_grant", grant, 3'b100);
    check("t4_next_ack", m_ack, 3'b100);
    tick();
    check("t4_release", grant, 3'b000);

    // DMA1 abandons mid-wait; pending CPU read granted after
    s_lat = -1;
    set_req(1, 1'b1, 1'b0, 32'h1000_0080, 32'h0);
    tick();
    check("t5_grant", grant, 3'b010);
    tick();
    check("t5_wait_ack", m_ack, 3'b000);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(0, 1'b1, 1'b0, 32'h0000_0300, 32'h0);
    s_lat = 0;
    #1;
    check("t5_drop_scyc", s_cyc, 1'b0);
    check("t5_drop_sstb", s_stb, 1'b0);
    check("t5_drop_ack", m_ack, 3'b000);
    tick();
    check("t5_idle", grant, 3'b000);
    check("t5_idle_ack", m_ack, 3'b000);
    tick();
    check("t5_cpu_grant", grant, 3'b001);
    check("t5_cpu_adr", s_adr, 32'h0000_0300);
    check("t5_cpu_ack", m_ack, 3'b001);
    check("t5_cpu_data", m_dat_r, 32'hCAFE_F00D);
    tick();
    check("t5_release", grant, 3'b000);

    // Reset during OWN; afterwards DMA1 wins the first DMA-only contest
    s_lat = -1;
    set_req(1, 1'b1, 1'b0, 32'h1000_00C0, 32'h0);
    tick();
    check("t6_grant", grant, 3'b010);
    check("t6_scyc", s_cyc, 1'b1);
    #1 wb_rst_n = 1'b0;
    #1;
    check("t6_rst_scyc", s_cyc, 1'b0);
    check("t6_rst_grant", grant, 3'b000);
    check("t6_rst_ack", m_ack, 3'b000);
    set_req(2, 1'b1, 1'b0, 32'h2000_00C0, 32'h0);
    tick();
    wb_rst_n = 1'b1;
    tick();
    check("t6_after_grant", grant, 3'b010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
